// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the pipeline memory
// stage (master) and the data-memory responder (slave).
//   MemRead/MemWrite : load/store request, held stable while Busy=1
//   Addr             : byte address
//   WData            : store data
//   RData            : registered load data
//   Ready            : one-cycle completion pulse
//   Busy             : access in progress, pipeline stalls
//   AddrErr          : invalid-access flag, meaningful only with Ready
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Ready;
  logic        Busy;
  logic        AddrErr;

  modport master (
    output MemRead, MemWrite, Addr, WData,
    input  RData, Ready, Busy, AddrErr
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WData,
    output RData, Ready, Busy, AddrErr
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with a fixed number of wait
// states. A request is accepted in IDLE, optionally waits WAIT_CYCLES edges,
// and completes with a one-cycle Ready pulse (RESP) carrying RData/AddrErr.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset (array contents are kept)
//   bus  : dmem_responder_if.slave request/response bundle
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  dmem_responder_if.slave       bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int         IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [1:0]    state_r;
  logic [3:0]    cnt_r;
  logic          rd_r;
  logic          wr_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   rdata_r;
  logic          ready_r;
  logic          busy_r;
  logic          err_r;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req_s;
  logic          acc_rd_s;
  logic          acc_wr_s;
  logic [31:0]   acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic          go_resp_s;
  logic          next_busy_s;
  logic          invalid_s;
  logic          mem_we_s;
  logic [IW-1:0] idx_s;

  // Access operands: with zero wait states the completing edge is also the
  // accepting edge, so the live inputs are used instead of the latched copy.
  always_comb begin
    req_s       = bus.MemRead | bus.MemWrite;
    acc_rd_s    = rd_r;
    acc_wr_s    = wr_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    if (state_r == IDLE) begin
      acc_rd_s    = bus.MemRead;
      acc_wr_s    = bus.MemWrite;
      acc_addr_s  = bus.Addr;
      acc_wdata_s = bus.WData;
    end else begin
      acc_rd_s    = rd_r;
      acc_wr_s    = wr_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
    invalid_s = (acc_addr_s[1:0] != 2'b00) ||
                (acc_addr_s[31:2] >= 30'(DEPTH_WORDS)) ||
                (acc_rd_s && acc_wr_s);
    idx_s     = acc_addr_s[IW+1:2];
  end

  // Transition decode: which edge completes the access and which keeps Busy.
  always_comb begin
    go_resp_s   = 1'b0;
    next_busy_s = 1'b0;
    case (state_r)
      IDLE: begin
        go_resp_s   = req_s && (WAIT_INIT == 4'd0);
        next_busy_s = req_s && (WAIT_INIT != 4'd0);
      end
      WAIT: begin
        go_resp_s   = (cnt_r == 4'd1);
        next_busy_s = (cnt_r != 4'd1);
      end
      default: begin
        go_resp_s   = 1'b0;
        next_busy_s = 1'b0;
      end
    endcase
    // RST gates the write so a held request cannot slip in while resetting.
    mem_we_s = go_resp_s && acc_wr_s && !invalid_s && !RST;
  end

  // Storage array write port; deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem[idx_s] <= acc_wdata_s;
    end
  end

  // Control FSM, request latch and registered response outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
      rdata_r <= 32'h0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= go_resp_s;
      busy_r  <= next_busy_s;
      err_r   <= go_resp_s && invalid_s;
      if (go_resp_s) begin
        if (invalid_s) begin
          rdata_r <= 32'h0;
        end else if (acc_rd_s) begin
          rdata_r <= mem[idx_s];
        end else begin
          rdata_r <= rdata_r;
        end
      end
      case (state_r)
        IDLE: begin
          if (req_s) begin
            rd_r    <= bus.MemRead;
            wr_r    <= bus.MemWrite;
            addr_r  <= bus.Addr;
            wdata_r <= bus.WData;
            if (WAIT_INIT == 4'd0) begin
              state_r <= RESP;
            end else begin
              state_r <= WAIT;
              cnt_r   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r <= RESP;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.RData   = rdata_r;
  assign bus.Ready   = ready_r;
  assign bus.Busy    = busy_r;
  assign bus.AddrErr = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against
// a behavioural model (word array + expected latency). Two instances are
// used: one with two wait states, one with zero wait states.
module tb_dmem_responder;
  localparam int WA = 2;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  logic [31:0] model_mem [64];
  logic [31:0] exp_rdata_a;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(WA)) dut_a (
    .CLK(CLK), .RST(RST), .bus(bus_a)
  );
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_b (
    .CLK(CLK), .RST(RST), .bus(bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access on instance A, started #1 after an edge with A idle.
  task automatic acc_a(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd);
    logic        err;
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    err = (addr[1:0] != 2'b00) || (idx >= 32'd64) || (rd && wr);
    bus_a.MemRead  = rd;
    bus_a.MemWrite = wr;
    bus_a.Addr     = addr;
    bus_a.WData    = wd;
    for (int k = 0; k < WA; k++) begin
      @(posedge CLK); #1;
      check("busy_wait", {31'h0, bus_a.Busy}, 32'd1);
      check("ready_wait", {31'h0, bus_a.Ready}, 32'd0);
      // Everything seen while busy must be ignored.
      bus_a.MemRead  = 1'($urandom);
      bus_a.MemWrite = 1'($urandom);
      bus_a.Addr     = $urandom;
      bus_a.WData    = 32'hFFFFFFFF;
    end
    if (err) begin
      exp_rdata_a = 32'h0;
    end else if (rd) begin
      exp_rdata_a = model_mem[idx[5:0]];
    end else if (wr) begin
      model_mem[idx[5:0]] = wd;
    end
    @(posedge CLK); #1;
    check("ready_resp", {31'h0, bus_a.Ready}, 32'd1);
    check("busy_resp", {31'h0, bus_a.Busy}, 32'd0);
    check("err_resp", {31'h0, bus_a.AddrErr}, {31'h0, err});
    check("rdata_resp", bus_a.RData, exp_rdata_a);
    bus_a.MemRead  = 1'b0;
    bus_a.MemWrite = 1'b0;
    @(posedge CLK); #1;
    check("ready_idle", {31'h0, bus_a.Ready}, 32'd0);
    check("err_idle", {31'h0, bus_a.AddrErr}, 32'd0);
    check("rdata_hold", bus_a.RData, exp_rdata_a);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          sel;
    total = 0;
    bad   = 0;
    exp_rdata_a = 32'h0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    RST = 1'b0;
    bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0; bus_a.Addr = 32'h0; bus_a.WData = 32'h0;
    bus_b.MemRead = 1'b0; bus_b.MemWrite = 1'b0; bus_b.Addr = 32'h0; bus_b.WData = 32'h0;
    #1 RST = 1'b1;
    #1;
    check("rst_rdata", bus_a.RData, 32'h0);
    check("rst_ready", {31'h0, bus_a.Ready}, 32'd0);
    check("rst_busy", {31'h0, bus_a.Busy}, 32'd0);
    check("rst_err", {31'h0, bus_a.AddrErr}, 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;

    // Directed: write then read back, accepted on first edge after reset.
    acc_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    acc_a(1'b1, 1'b0, 32'h10, 32'h0);
    // Known contents for the words used below.
    for (int i = 0; i < 16; i++) begin
      if (i != 4) acc_a(1'b0, 1'b1, 32'(i * 4), 32'h0);
    end
    // Invalid accesses.
    acc_a(1'b1, 1'b0, 32'h12, 32'h0);
    acc_a(1'b0, 1'b1, 32'h100, 32'h55AA55AA);
    acc_a(1'b1, 1'b1, 32'h10, 32'h0);
    acc_a(1'b1, 1'b0, 32'h10, 32'h0);

    // Reset in the middle of a pending write.
    bus_a.MemWrite = 1'b1; bus_a.Addr = 32'h20; bus_a.WData = 32'h12345678;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    bus_a.MemWrite = 1'b0;
    #1;
    check("mid_rst_rdata", bus_a.RData, 32'h0);
    check("mid_rst_ready", {31'h0, bus_a.Ready}, 32'd0);
    check("mid_rst_busy", {31'h0, bus_a.Busy}, 32'd0);
    check("mid_rst_err", {31'h0, bus_a.AddrErr}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_rdata_a = 32'h0;
    acc_a(1'b1, 1'b0, 32'h20, 32'h0);

    // WData disturbed while waiting must not reach the array.
    acc_a(1'b0, 1'b1, 32'h24, 32'h11223344);
    acc_a(1'b1, 1'b0, 32'h24, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      a   = 32'($urandom_range(0, 15)) << 2;
      d   = $urandom;
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      if (sel == 1) a = 32'($urandom_range(64, 1000)) << 2;
      if (sel == 2) acc_a(1'b1, 1'b1, a, d);
      else if (sel < 6) acc_a(1'b1, 1'b0, a, d);
      else acc_a(1'b0, 1'b1, a, d);
    end

    // Zero wait states: write, then a held read re-accepted every 2 cycles.
    bus_b.MemWrite = 1'b1; bus_b.Addr = 32'h10; bus_b.WData = 32'hCAFEF00D;
    @(posedge CLK); #1;
    check("b_wr_ready", {31'h0, bus_b.Ready}, 32'd1);
    check("b_wr_busy", {31'h0, bus_b.Busy}, 32'd0);
    check("b_wr_err", {31'h0, bus_b.AddrErr}, 32'd0);
    bus_b.MemWrite = 1'b0;
    @(posedge CLK); #1;
    check("b_wr_idle", {31'h0, bus_b.Ready}, 32'd0);
    bus_b.MemRead = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      check("b_rd_ready", {31'h0, bus_b.Ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("b_rd_busy", {31'h0, bus_b.Busy}, 32'd0);
      check("b_rd_data", bus_b.RData, 32'hCAFEF00D);
    end
    bus_b.MemRead = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit words in the storage array.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and response (legal range 0..15).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 MemRead  input  1  load request from the pipeline memory stage.
REQ-006 MemWrite  input  1  store request from the pipeline memory stage.
REQ-007 Addr  input  32  byte address (ALU result).
REQ-008 WData  input  32  store data (rd2 forwarded through EX/MEM).
REQ-009 RData  output  32  registered load data toward MEM/WB.
REQ-010 Ready  output  1  one-cycle response pulse; the access has completed.
REQ-011 Busy  output  1  access in progress; the pipeline shall stall and hold its request stable.
REQ-012 AddrErr  output  1  error flag, valid only while Ready=1.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE, a rising edge with MemRead|MemWrite=1 SHALL accept the request and latch Addr, WData and the operation; this edge is E0.
REQ-015 From E0 the FSM SHALL enter WAIT with counter=WAIT_CYCLES if WAIT_CYCLES>0, otherwise RESP.
REQ-016 In WAIT, each edge SHALL decrement the counter, and the edge on which counter==1 SHALL enter RESP; RESP is therefore entered at edge E0+WAIT_CYCLES.
REQ-017 RESP SHALL return to IDLE on the next edge unconditionally, so Ready is high for exactly one cycle.
REQ-018 Busy SHALL be 1 exactly while the state is WAIT, and 0 in IDLE and RESP.
REQ-019 Requests present while the state is WAIT or RESP SHALL be ignored; the latched values are not updated.
REQ-020 On entry to RESP, a valid write SHALL store the latched WData at word index Addr[31:2], and RData SHALL hold its previous value.
REQ-021 On entry to RESP, a valid read SHALL load RData with the word at Addr[31:2]; RData SHALL hold that value until the next read response.
REQ-022 A request SHALL be invalid if Addr[1:0]!=0, or Addr[31:2]>=DEPTH_WORDS, or MemRead and MemWrite are both 1.
REQ-023 For an invalid request: normal latency, AddrErr=1 with Ready, no array write, and RData set to 0.
REQ-024 AddrErr SHALL be 0 whenever Ready=0.
REQ-025 A request held high continuously SHALL be re-accepted at the first edge in IDLE after RESP; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-026 A read following a write to the same word SHALL return the newly written data.

Reset
REQ-027 While RST=1: state=IDLE, counter=0, RData=0x00000000, Ready=0, Busy=0, AddrErr=0, effective immediately without waiting for a clock edge.
REQ-028 RST during WAIT SHALL discard the pending access; a pending write SHALL NOT modify the array.
REQ-029 Array contents SHALL NOT be cleared by RST; simulation initialises the array to zero.
REQ-030 The first request SHALL be accepted on the first rising edge after RST deasserts.

Verification
REQ-031 WAIT_CYCLES=2: write Addr=0x10, WData=0xDEADBEEF at E0 -> Busy=1 after E0 and E1; Ready=1, AddrErr=0 after E2; IDLE after E3.
REQ-032 Read Addr=0x10 following REQ-031 -> Ready pulse 2 edges after acceptance with RData=0xDEADBEEF; RData holds after the pulse.
REQ-033 Read Addr=0x12 (misaligned), then write Addr=0x100 (index 64, out of range), then MemRead=MemWrite=1 -> each gives Ready with AddrErr=1 and RData=0; word 0x10 still reads 0xDEADBEEF.
REQ-034 Write Addr=0x20, WData=0x12345678, RST pulsed after E1 -> all outputs 0 immediately; a later read of 0x20 returns 0x00000000.
REQ-035 WAIT_CYCLES=0, MemRead held high on Addr=0x10 -> Ready=1 after E0, Busy never 1, re-accepted every 2 cycles.
REQ-036 WData changed to 0xFFFFFFFF during WAIT of a write to 0x24 -> array word 0x24 holds the value latched at E0.
